// File: rtl/compare_sweep_ctrl.sv
// Clocked sweep sequencer around an unsigned comparator: holds A, steps B over all values, tallies GT/EQ/LT.
// Optional SWEEP_CHECK_EN adds a sticky cross-check of the six comparator flags (err / err_step).
module compare_sweep_ctrl #(
    parameter int WIDTH       = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] val_a,
    output logic [WIDTH-1:0] val_b,
    input  logic             a_gt_b,
    input  logic             a_ge_b,
    input  logic             a_lt_b,
    input  logic             a_le_b,
    input  logic             a_eq_b,
    input  logic             a_ne_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   gt_count,
    output logic [WIDTH:0]   eq_count,
    output logic [WIDTH:0]   lt_count,
    output logic             err,
    output logic [WIDTH-1:0] err_step
);

    // Counter is one bit wider than needed for HOLD_CYCLES-1 so it may run one past the terminal value.
    localparam int             CW          = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0]  SETTLE_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_settle;
    logic [WIDTH-1:0] r_val_a;
    logic [WIDTH-1:0] r_val_b;
    logic [WIDTH:0]   r_gt;
    logic [WIDTH:0]   r_eq;
    logic [WIDTH:0]   r_lt;
    logic             w_last;
    logic             w_accept;

    assign w_last   = (r_val_b == {WIDTH{1'b1}});
    assign w_accept = (r_state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SETTLE;
            SETTLE:  if (r_settle == SETTLE_LAST) w_next = SAMPLE;
            SAMPLE:  w_next = w_last ? DONE : SETTLE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SETTLE) || (r_state == SAMPLE);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle <= '0;
            r_val_a  <= '0;
            r_val_b  <= '0;
            r_gt     <= '0;
            r_eq     <= '0;
            r_lt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_val_a  <= a_in;
                        r_val_b  <= '0;
                        r_settle <= '0;
                        r_gt     <= '0;
                        r_eq     <= '0;
                        r_lt     <= '0;
                    end
                end
                SETTLE: begin
                    r_settle <= r_settle + 1'b1;
                end
                SAMPLE: begin
                    r_gt <= r_gt + {{WIDTH{1'b0}}, a_gt_b};
                    r_eq <= r_eq + {{WIDTH{1'b0}}, a_eq_b};
                    r_lt <= r_lt + {{WIDTH{1'b0}}, a_lt_b};
                    if (!w_last) begin
                        r_val_b  <= r_val_b + 1'b1;
                        r_settle <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign val_a    = r_val_a;
    assign val_b    = r_val_b;
    assign gt_count = r_gt;
    assign eq_count = r_eq;
    assign lt_count = r_lt;

`ifdef SWEEP_CHECK_EN
    logic             r_err;
    logic [WIDTH-1:0] r_err_step;
    logic             w_bad;

    always_comb begin
        w_bad = (a_ge_b != (a_gt_b | a_eq_b)) ||
                (a_le_b != (a_lt_b | a_eq_b)) ||
                (a_ne_b != ~a_eq_b) ||
                (({1'b0, a_gt_b} + {1'b0, a_eq_b} + {1'b0, a_lt_b}) != 2'd1);
    end

    // Only the first inconsistent step is recorded; err stays set until the next sweep starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_step <= '0;
        end else if (w_accept) begin
            r_err      <= 1'b0;
            r_err_step <= '0;
        end else if ((r_state == SAMPLE) && w_bad && !r_err) begin
            r_err      <= 1'b1;
            r_err_step <= r_val_b;
        end
    end

    assign err      = r_err;
    assign err_step = r_err_step;
`else
    // The redundant flags have no consumer without the checker.
    logic w_unused_flags;
    assign w_unused_flags = &{1'b0, a_ge_b, a_le_b, a_ne_b, w_accept};
    assign err      = 1'b0;
    assign err_step = '0;
`endif

endmodule

// File: tb/tb_compare_sweep_ctrl.sv
// Directed bench for compare_sweep_ctrl: default HOLD_CYCLES=4 instance plus a HOLD_CYCLES=1 instance.
// Cycle k is the clock period following rising edge k-1, where edge 0 is the accepted start edge.
module tb_compare_sweep_ctrl;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start1;
    logic [W-1:0] a_in, a_in1;

    logic [W-1:0] val_a, val_b, err_step;
    logic         busy, done, err;
    logic [W:0]   gt_count, eq_count, lt_count;
    logic         gt, ge, lt, le, eq, ne;

    logic [W-1:0] val_a1, val_b1, err_step1;
    logic         busy1, done1, err1;
    logic [W:0]   gt_count1, eq_count1, lt_count1;
    logic         gt1, ge1, lt1, le1, eq1, ne1;

    logic         fault_ge_en, fault_ne_en;
    logic [W-1:0] fault_ge_val, fault_ne_val;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    compare_sweep_ctrl #(.WIDTH(W), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in),
        .val_a(val_a), .val_b(val_b),
        .a_gt_b(gt), .a_ge_b(ge), .a_lt_b(lt), .a_le_b(le), .a_eq_b(eq), .a_ne_b(ne),
        .busy(busy), .done(done),
        .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count),
        .err(err), .err_step(err_step)
    );

    compare_sweep_ctrl #(.WIDTH(W), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a_in1),
        .val_a(val_a1), .val_b(val_b1),
        .a_gt_b(gt1), .a_ge_b(ge1), .a_lt_b(lt1), .a_le_b(le1), .a_eq_b(eq1), .a_ne_b(ne1),
        .busy(busy1), .done(done1),
        .gt_count(gt_count1), .eq_count(eq_count1), .lt_count(lt_count1),
        .err(err1), .err_step(err_step1)
    );

    // Ideal comparator models, with optional corruption of ge/ne at chosen B values.
    always_comb begin
        gt = (val_a > val_b);
        lt = (val_a < val_b);
        eq = (val_a == val_b);
        ge = (val_a >= val_b);
        le = (val_a <= val_b);
        ne = (val_a != val_b);
        if (fault_ge_en && (val_b == fault_ge_val)) ge = 1'b0;
        if (fault_ne_en && (val_b == fault_ne_val)) ne = 1'b0;
    end

    always_comb begin
        gt1 = (val_a1 > val_b1);
        lt1 = (val_a1 < val_b1);
        eq1 = (val_a1 == val_b1);
        ge1 = (val_a1 >= val_b1);
        le1 = (val_a1 <= val_b1);
        ne1 = (val_a1 != val_b1);
    end

    task automatic pulse_start(input logic [W-1:0] a);
        @(negedge clk);
        a_in  = a;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_start1(input logic [W-1:0] a);
        @(negedge clk);
        a_in1  = a;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        tests++;
        if ({val_a, val_b, gt_count, eq_count, lt_count, err, err_step, busy, done} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got va=%0d vb=%0d gt=%0d eq=%0d lt=%0d err=%0b step=%0d busy=%0b done=%0b, want all 0",
                     val_a, val_b, gt_count, eq_count, lt_count, err, err_step, busy, done);
        end
        tests++;
        if ({val_a1, val_b1, gt_count1, eq_count1, lt_count1, err1, err_step1, busy1, done1} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs_h1: got nonzero outputs, want all 0");
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_sweep;
        logic [W-1:0] exp_vb;
        int bad_busy = 0, bad_done = 0, bad_vb = 0;
        pulse_start(3'd4);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            exp_vb = (k <= 40) ? 3'((k - 1) / 5) : 3'd7;
            if (busy !== (k <= 40)) bad_busy++;
            if (done !== (k == 41)) bad_done++;
            if (val_b !== exp_vb) bad_vb++;
            if (k == 1) begin
                tests++;
                if (val_a !== 3'd4) begin
                    fails++;
                    $display("[TB] FAIL basic_val_a: got %0d, want 4", val_a);
                end
            end
        end
        tests++;
        if (bad_busy != 0) begin
            fails++;
            $display("[TB] FAIL basic_busy_window: %0d cycles wrong, want busy high cycles 1-40 only", bad_busy);
        end
        tests++;
        if (bad_done != 0) begin
            fails++;
            $display("[TB] FAIL basic_done_pulse: %0d cycles wrong, want done only in cycle 41", bad_done);
        end
        tests++;
        if (bad_vb != 0) begin
            fails++;
            $display("[TB] FAIL basic_val_b_steps: %0d cycles wrong, want each B held 5 cycles", bad_vb);
        end
        tests++;
        if ({gt_count, eq_count, lt_count} !== {4'd4, 4'd1, 4'd3}) begin
            fails++;
            $display("[TB] FAIL basic_counts: got %0d/%0d/%0d, want 4/1/3", gt_count, eq_count, lt_count);
        end
        tests++;
        if ((int'(gt_count) + int'(eq_count) + int'(lt_count)) != 8) begin
            fails++;
            $display("[TB] FAIL basic_sum: got %0d, want 8", int'(gt_count) + int'(eq_count) + int'(lt_count));
        end
    endtask

    task automatic test_extremes;
        int cyc;
        pulse_start(3'd0);
        wait_done(cyc);
        tests++;
        if (cyc != 41) begin
            fails++;
            $display("[TB] FAIL a0_done_cycle: got %0d, want 41", cyc);
        end
        tests++;
        if ({gt_count, eq_count, lt_count} !== {4'd0, 4'd1, 4'd7}) begin
            fails++;
            $display("[TB] FAIL a0_counts: got %0d/%0d/%0d, want 0/1/7", gt_count, eq_count, lt_count);
        end
        pulse_start(3'd7);
        @(negedge clk);
        tests++;
        if ({gt_count, eq_count, lt_count} !== '0) begin
            fails++;
            $display("[TB] FAIL a7_counts_cleared: got %0d/%0d/%0d, want 0/0/0", gt_count, eq_count, lt_count);
        end
        wait_done(cyc);
        tests++;
        if ({gt_count, eq_count, lt_count} !== {4'd7, 4'd1, 4'd0} || cyc != 40) begin
            fails++;
            $display("[TB] FAIL a7_counts: got %0d/%0d/%0d done+%0d, want 7/1/0 done+40",
                     gt_count, eq_count, lt_count, cyc);
        end
    endtask

    task automatic test_back_to_back;
        int done_cnt = 0, done_at = -1, bad_va = 0;
        pulse_start(3'd4);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (val_a !== 3'd4) bad_va++;
            start = (k == 10);
            if (k == 12) a_in = 3'd2;
        end
        start = 1'b0;
        tests++;
        if (done_cnt != 1 || done_at != 41) begin
            fails++;
            $display("[TB] FAIL restart_done: got %0d pulses last at %0d, want 1 at 41", done_cnt, done_at);
        end
        tests++;
        if (bad_va != 0) begin
            fails++;
            $display("[TB] FAIL restart_val_a: %0d cycles not 4, want val_a held at 4", bad_va);
        end
        tests++;
        if ({gt_count, eq_count, lt_count} !== {4'd4, 4'd1, 4'd3}) begin
            fails++;
            $display("[TB] FAIL restart_counts: got %0d/%0d/%0d, want 4/1/3", gt_count, eq_count, lt_count);
        end
    endtask

    task automatic test_reset_midsweep;
        int cyc;
        pulse_start(3'd5);
        for (int k = 1; k <= 20; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({val_a, val_b, gt_count, eq_count, lt_count, err, err_step, busy, done} !== '0) begin
            fails++;
            $display("[TB] FAIL midreset_outputs: got va=%0d vb=%0d gt=%0d eq=%0d lt=%0d busy=%0b, want all 0",
                     val_a, val_b, gt_count, eq_count, lt_count, busy);
        end
        #1 rst = 1'b0;
        pulse_start(3'd6);
        wait_done(cyc);
        tests++;
        if (cyc != 41 || {gt_count, eq_count, lt_count} !== {4'd6, 4'd1, 4'd1}) begin
            fails++;
            $display("[TB] FAIL midreset_resweep: got %0d/%0d/%0d done at %0d, want 6/1/1 at 41",
                     gt_count, eq_count, lt_count, cyc);
        end
    endtask

    task automatic test_err_check;
        logic exp_e15, exp_e16, exp_err;
        logic [W-1:0] exp_step;
        logic e15, e16;
`ifdef SWEEP_CHECK_EN
        exp_e15 = 1'b0; exp_e16 = 1'b1; exp_err = 1'b1; exp_step = 3'd2;
`else
        exp_e15 = 1'b0; exp_e16 = 1'b0; exp_err = 1'b0; exp_step = 3'd0;
`endif
        e15 = 1'bx;
        e16 = 1'bx;
        fault_ge_en = 1'b1; fault_ge_val = 3'd2;
        fault_ne_en = 1'b1; fault_ne_val = 3'd5;
        pulse_start(3'd4);
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k == 15) e15 = err;
            if (k == 16) e16 = err;
        end
        tests++;
        if (e15 !== exp_e15 || e16 !== exp_e16) begin
            fails++;
            $display("[TB] FAIL err_onset: got c15=%0b c16=%0b, want c15=%0b c16=%0b", e15, e16, exp_e15, exp_e16);
        end
        tests++;
        if (err !== exp_err || err_step !== exp_step || done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL err_at_done: got err=%0b step=%0d done=%0b, want err=%0b step=%0d done=1",
                     err, err_step, done, exp_err, exp_step);
        end
        tests++;
        if ({gt_count, eq_count, lt_count} !== {4'd4, 4'd1, 4'd3}) begin
            fails++;
            $display("[TB] FAIL err_counts: got %0d/%0d/%0d, want 4/1/3", gt_count, eq_count, lt_count);
        end
        fault_ge_en = 1'b0;
        fault_ne_en = 1'b0;
        pulse_start(3'd4);
        @(negedge clk);
        tests++;
        if (err !== 1'b0 || err_step !== 3'd0) begin
            fails++;
            $display("[TB] FAIL err_cleared: got err=%0b step=%0d, want 0/0", err, err_step);
        end
        for (int k = 2; k <= 41; k++) @(negedge clk);
        tests++;
        if (err !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL err_clean_sweep: got err=%0b done=%0b, want err=0 done=1", err, done);
        end
    endtask

    task automatic test_hold1;
        logic [W-1:0] exp_vb;
        int bad_busy = 0, bad_done = 0, bad_vb = 0;
        pulse_start1(3'd4);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_vb = (k <= 16) ? 3'((k - 1) / 2) : 3'd7;
            if (busy1 !== (k <= 16)) bad_busy++;
            if (done1 !== (k == 17)) bad_done++;
            if (val_b1 !== exp_vb) bad_vb++;
        end
        tests++;
        if (bad_busy != 0 || bad_done != 0) begin
            fails++;
            $display("[TB] FAIL hold1_timing: %0d busy and %0d done cycles wrong, want done at 17", bad_busy, bad_done);
        end
        tests++;
        if (bad_vb != 0) begin
            fails++;
            $display("[TB] FAIL hold1_val_b: %0d cycles wrong, want B held 2 cycles", bad_vb);
        end
        tests++;
        if ({gt_count1, eq_count1, lt_count1} !== {4'd4, 4'd1, 4'd3}) begin
            fails++;
            $display("[TB] FAIL hold1_counts: got %0d/%0d/%0d, want 4/1/3", gt_count1, eq_count1, lt_count1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; start1 = 1'b0;
        a_in = '0; a_in1 = '0;
        fault_ge_en = 1'b0; fault_ne_en = 1'b0;
        fault_ge_val = '0; fault_ne_val = '0;
        test_reset;
        test_basic_sweep;
        test_extremes;
        test_back_to_back;
        test_reset_midsweep;
        test_err_check;
        test_hold1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
